// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment scanner.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic {
    OFF  = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic [1:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic is_bcd(input logic [3:0] n);
    return n <= 4'd9;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-high segment pattern decoder.
// Non-BCD nibbles show a dash; blank overrides everything.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed BCD display scanner with tear-free frame updates.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        bcd_err
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_t           digit_q, digit_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic       bad_nibble;
  logic [3:0] cur_nib;
  logic [3:0] sel;
  logic       blank;
  logic [6:0] seg_pat;

  assign tick      = (state_q == SCAN) && (cnt_q == CNT_MAX);
  assign frame_end = tick && (digit_q == 2'd3);
  assign cur_nib   = disp_q[{digit_q, 2'b00} +: 4];
  assign sel       = 4'b0001 << digit_q;

  assign bad_nibble = !is_bcd(bcd_in[3:0])  ||
                      !is_bcd(bcd_in[7:4])  ||
                      !is_bcd(bcd_in[11:8]) ||
                      !is_bcd(bcd_in[15:12]);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    unique case (digit_q)
      2'd3:    blank = (disp_q[15:12] == 4'h0);
      2'd2:    blank = (disp_q[15:8] == 8'h00);
      2'd1:    blank = (disp_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_dec (
    .nibble (cur_nib),
    .blank  (blank),
    .seg    (seg_pat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    seg_d      = SEG_OFF;
    an_d       = AN_OFF;

    unique case (state_q)
      OFF: begin
        cnt_d   = '0;
        digit_d = '0;
        if (en) state_d = SCAN;
        if (pend_vld_q) begin
          disp_d     = pend_q;
          pend_vld_d = 1'b0;
        end
      end
      SCAN: begin
        if (!en) state_d = OFF;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) digit_d = digit_q + 2'd1;
        an_d  = AN_ACTIVE_LOW ? ~sel : sel;
        seg_d = SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
        if (frame_end && pend_vld_q) begin
          disp_d     = pend_q;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = OFF;
    endcase

    // A strobe on the frame boundary bypasses the pending slot.
    if (bcd_valid) begin
      pend_d     = bcd_in;
      pend_vld_d = 1'b1;
      if (bad_nibble) err_d = 1'b1;
      if (frame_end) begin
        disp_d     = bcd_in;
        pend_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      digit_q    <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: SCAN_DIV=4, active-low seg and an.
// Expected frames are queued per sample and popped as the DUT drives them.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  seg7_scan #(
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .en        (en),
    .seg       (seg),
    .an        (an),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [15:0] hi;
    hi = v >> (4 * d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && hi == 16'h0000) return 7'h7F;
`endif
    return ~pat(hi[3:0]);
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic [15:0] v, input int k);
    exp_t e;
    logic [3:0] one;
    int d;
    one = 4'b0001;
    d = (k / 4) % 4;
    e.an  = ~(one << d);
    e.seg = exp_seg(v, d);
    sb.push_back(e);
  endtask

  task automatic run_scan(input int n, input int k1, input logic [15:0] v1,
                          input int k2, input logic [15:0] v2);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: sample %0d has no expectation", k);
      end else begin
        e = sb.pop_front();
        chk("scan_an", {12'h0, an}, {12'h0, e.an});
        chk("scan_seg", {9'h0, seg}, {9'h0, e.seg});
      end
      bcd_valid = (k == k1) || (k == k2);
      bcd_in    = (k == k2) ? v2 : v1;
    end
    bcd_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    bcd_in    = v;
    bcd_valid = 1'b1;
    @(posedge clk); #1;
    bcd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic enable();
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic disable_chk();
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("off_an", {12'h0, an}, 16'h000F);
    chk("off_seg", {9'h0, seg}, 16'h007F);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{bcd: 16'h1234, err: 1'b0};
    vecs[1] = '{bcd: 16'h9876, err: 1'b0};
    vecs[2] = '{bcd: 16'h0007, err: 1'b0};
    vecs[3] = '{bcd: 16'h0500, err: 1'b0};
    vecs[4] = '{bcd: 16'h0000, err: 1'b0};
    vecs[5] = '{bcd: 16'h12A4, err: 1'b1};

    rst = 1'b1; en = 1'b0; bcd_valid = 1'b0; bcd_in = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_an", {12'h0, an}, 16'h000F);
      chk("rst_seg", {9'h0, seg}, 16'h007F);
      chk("rst_err", {15'h0, bcd_err}, 16'h0000);
    end

    // Table: load in OFF, scan one full frame, check sticky error.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      load(vecs[i].bcd);
      @(negedge clk);
      chk("load_off_an", {12'h0, an}, 16'h000F);
      @(posedge clk); #1;
      enable();
      for (int k = 0; k < 16; k++) push(vecs[i].bcd, k);
      run_scan(16, -1, 16'h0, -1, 16'h0);
      chk("vec_err", {15'h0, bcd_err}, {15'h0, vecs[i].err});
      disable_chk();
    end

    // Error flag survives a later valid value.
    @(posedge clk); #1;
    load(16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_sticky", {15'h0, bcd_err}, 16'h0001);
    end

    // Tear-free: new value arrives while digit 1 is driven.
    @(posedge clk); #1;
    load(16'h1234);
    enable();
    for (int k = 0; k < 20; k++) push(k < 16 ? 16'h1234 : 16'h5678, k);
    run_scan(20, 4, 16'h5678, -1, 16'h0);
    disable_chk();

    // Pending 1111, then 2222 on the frame-boundary cycle.
    @(posedge clk); #1;
    enable();
    for (int k = 0; k < 36; k++) push(k < 16 ? 16'h5678 : 16'h2222, k);
    run_scan(36, 2, 16'h1111, 14, 16'h2222);
    disable_chk();

    // Reset discards a simultaneous capture and clears the display.
    @(negedge clk);
    rst = 1'b1; bcd_valid = 1'b1; bcd_in = 16'h9999;
    @(posedge clk); #1;
    bcd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_err", {15'h0, bcd_err}, 16'h0000);
    chk("rst2_an", {12'h0, an}, 16'h000F);
    @(posedge clk); #1;
    enable();
    for (int k = 0; k < 16; k++) push(16'h0000, k);
    run_scan(16, -1, 16'h0, -1, 16'h0);
    disable_chk();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_left: %0d entries remain, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
